timer_reg_bank: RTL

Parametrised multi-channel timer result register for the RTC display path. Each of CHANNELS lanes latches either the remaining time (count minus RTC value) or the raw count, on an update strobe. Per-lane hold, saturating and wrap-around subtraction modes, borrow flags and a sticky expiry alarm with acknowledge are provided. A registered read port feeds the VGA text generator one lane at a time.

---
 rtl/timer_reg_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/timer_reg_bank.sv
// Multi-lane timer result register: per-lane capture of remaining or raw time,
// borrow flags, sticky expiry alarm with acknowledge, and a registered read port.
module timer_reg_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       hold,
  input  logic [CHANNELS*WIDTH-1:0] in_count_dato,
  input  logic [CHANNELS*WIDTH-1:0] in_rtc_dato,
  input  logic                      exp_ack,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          out_dato_vga,
  output logic [CHANNELS*WIDTH-1:0] out_regs,
  output logic [CHANNELS-1:0]       borrow,
  output logic                      expired
);

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_EXPIRED
  } state_t;

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'b00,
    MODE_PASS  = 2'b01,
    MODE_SAT   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CHANNELS*WIDTH-1:0]   r_regs;
  logic [CHANNELS*WIDTH-1:0]   w_regs_next;
  logic [CHANNELS-1:0]         r_borrow;
  logic [CHANNELS-1:0]         w_borrow_next;
  logic [WIDTH-1:0]            r_dato_vga;
  logic [WIDTH-1:0]            w_rd_data;
  logic                        w_zero;
  logic                        w_clear;
  mode_t                       w_mode;
  logic [WIDTH-1:0]            w_cnt  [CHANNELS];
  logic [WIDTH-1:0]            w_rtc  [CHANNELS];
  logic [WIDTH-1:0]            w_diff [CHANNELS];
  logic [CHANNELS-1:0]         w_lt;

  assign w_mode  = mode_t'(mode);
  assign w_clear = (w_mode == MODE_CLEAR);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_cnt[g]  = in_count_dato[g*WIDTH +: WIDTH];
    assign w_rtc[g]  = in_rtc_dato[g*WIDTH +: WIDTH];
    assign w_diff[g] = w_cnt[g] - w_rtc[g];
    assign w_lt[g]   = (w_rtc[g] > w_cnt[g]);
  end

  always_comb begin
    w_regs_next   = r_regs;
    w_borrow_next = r_borrow;
    if (upd_valid) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!hold[i]) begin
          unique case (w_mode)
            MODE_WRAP: begin
              w_regs_next[i*WIDTH +: WIDTH] = w_diff[i];
              w_borrow_next[i]              = w_lt[i];
            end
            MODE_PASS: begin
              w_regs_next[i*WIDTH +: WIDTH] = w_cnt[i];
              w_borrow_next[i]              = 1'b0;
            end
            MODE_SAT: begin
              w_regs_next[i*WIDTH +: WIDTH] = w_lt[i] ? '0 : w_diff[i];
              w_borrow_next[i]              = w_lt[i];
            end
            default: begin
              w_regs_next[i*WIDTH +: WIDTH] = '0;
              w_borrow_next[i]              = 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Z is evaluated on the post-capture values so expiry rises with the zeroed regs
  assign w_zero = (w_regs_next == '0);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_DISARMED: begin
        if (!w_zero) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (upd_valid && w_zero)
          w_state_next = w_clear ? ST_DISARMED : ST_EXPIRED;
      end
      ST_EXPIRED: begin
        if (exp_ack)
          w_state_next = w_zero ? ST_DISARMED : ST_ARMED;
      end
      default: w_state_next = ST_DISARMED;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_addr == ADDR_W'(i)) w_rd_data = r_regs[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs     <= '0;
      r_borrow   <= '0;
      r_dato_vga <= '0;
      r_state    <= ST_DISARMED;
    end else begin
      r_regs     <= w_regs_next;
      r_borrow   <= w_borrow_next;
      r_dato_vga <= w_rd_data;
      r_state    <= w_state_next;
    end
  end

  assign out_regs     = r_regs;
  assign borrow       = r_borrow;
  assign out_dato_vga = r_dato_vga;
  assign expired      = (r_state == ST_EXPIRED);

endmodule
